// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: decoded pipeline-register fields and mult/div status
// coming in, stall/flush/forward controls and debug status going out.
interface pipeline_hazard_ctrl_if;
  // F/D instruction sources
  logic [4:0]  fd_rs;
  logic [4:0]  fd_rt;
  logic        fd_uses_rs;
  logic        fd_uses_rt;
  // D/X instruction
  logic [4:0]  dx_rs;
  logic [4:0]  dx_rt;
  logic [4:0]  dx_rd;
  logic        dx_is_load;
  logic        dx_is_md;
  logic        branch_taken;
  // Later-stage writers
  logic [4:0]  xm_rd;
  logic [4:0]  mw_rd;
  logic        xm_we;
  logic        mw_we;
  // Mult/div unit status
  logic        md_ready;
  // Pipeline controls
  logic        stall_pc;
  logic        stall_fd;
  logic        stall_dx;
  logic        bubble_xm;
  logic        flush_fd;
  logic        flush_dx;
  logic        md_start;
  logic        md_result_we;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  // Status
  logic        md_timeout;
  logic [15:0] stall_count;
  logic [1:0]  state;

  // Pipeline datapath side: supplies fields, consumes controls.
  modport master (
    output fd_rs, fd_rt, fd_uses_rs, fd_uses_rt,
    output dx_rs, dx_rt, dx_rd, dx_is_load, dx_is_md, branch_taken,
    output xm_rd, mw_rd, xm_we, mw_we, md_ready,
    input  stall_pc, stall_fd, stall_dx, bubble_xm, flush_fd, flush_dx,
    input  md_start, md_result_we, fwd_a_sel, fwd_b_sel,
    input  md_timeout, stall_count, state
  );

  // Hazard controller side.
  modport slave (
    input  fd_rs, fd_rt, fd_uses_rs, fd_uses_rt,
    input  dx_rs, dx_rt, dx_rd, dx_is_load, dx_is_md, branch_taken,
    input  xm_rd, mw_rd, xm_we, mw_we, md_ready,
    output stall_pc, stall_fd, stall_dx, bubble_xm, flush_fd, flush_dx,
    output md_start, md_result_we, fwd_a_sel, fwd_b_sel,
    output md_timeout, stall_count, state
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use interlock, taken-branch
// flush, ALU operand forwarding, and a multi-cycle mult/div sequencer with a
// watchdog. All pipeline controls are decoded from the current state and
// inputs in the same cycle; only the FSM, watchdog and status are registered.
module pipeline_hazard_ctrl (
  input logic                   clock,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MD_ISSUE = 2'b01,
    MD_WAIT  = 2'b10,
    MD_DONE  = 2'b11
  } state_t;

  localparam logic [5:0] WD_LIMIT = 6'd63;

  state_t      state_q, state_d;
  logic [5:0]  wd_q, wd_d;
  logic        timeout_q, timeout_set;
  logic [15:0] count_q;
  logic        load_use;

  logic stall_pc, stall_fd, stall_dx, bubble_xm;
  logic flush_fd, flush_dx, md_start, md_result_we;

  // Forward source for one operand: X/M wins over M/W; $0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       xm_we,
    input logic [4:0] xm_rd,
    input logic       mw_we,
    input logic [4:0] mw_rd
  );
    if (xm_we && (xm_rd != 5'd0) && (xm_rd == src))
      return 2'b01;
    else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Load-use: the load in D/X writes a register the F/D instruction reads.
  always_comb begin
    load_use = bus.dx_is_load && (bus.dx_rd != 5'd0) &&
               ((bus.fd_uses_rs && (bus.fd_rs == bus.dx_rd)) ||
                (bus.fd_uses_rt && (bus.fd_rt == bus.dx_rd)));
  end

  // Next-state, watchdog and pipeline-control decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    wd_d         = wd_q;
    timeout_set  = 1'b0;
    stall_pc     = 1'b0;
    stall_fd     = 1'b0;
    stall_dx     = 1'b0;
    bubble_xm    = 1'b0;
    flush_fd     = 1'b0;
    flush_dx     = 1'b0;
    md_start     = 1'b0;
    md_result_we = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.branch_taken) begin
          // Wrong-path instructions are squashed; nothing else matters.
          flush_fd = 1'b1;
          flush_dx = 1'b1;
        end else begin
          if (load_use) begin
            stall_pc = 1'b1;
            stall_fd = 1'b1;
            flush_dx = 1'b1;
          end
          if (bus.dx_is_md) state_d = MD_ISSUE;
        end
      end
      MD_ISSUE: begin
        md_start  = 1'b1;
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        stall_dx  = 1'b1;
        bubble_xm = 1'b1;
        wd_d      = 6'd0;
        state_d   = MD_WAIT;
      end
      MD_WAIT: begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        stall_dx  = 1'b1;
        bubble_xm = 1'b1;
        if (bus.md_ready) begin
          wd_d    = 6'd0;
          state_d = MD_DONE;
        end else if (wd_q == WD_LIMIT) begin
          // Unit never answered: give up, flag it, and let the pipe run.
          timeout_set = 1'b1;
          wd_d        = 6'd0;
          state_d     = RUN;
        end else begin
          wd_d = wd_q + 6'd1;
        end
      end
      MD_DONE: begin
        md_result_we = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State, watchdog, sticky timeout and saturating stall counter.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= RUN;
      wd_q      <= 6'd0;
      timeout_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      if (timeout_set) timeout_q <= 1'b1;
      if (stall_pc && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
    end
  end

  assign bus.stall_pc     = stall_pc;
  assign bus.stall_fd     = stall_fd;
  assign bus.stall_dx     = stall_dx;
  assign bus.bubble_xm    = bubble_xm;
  assign bus.flush_fd     = flush_fd;
  assign bus.flush_dx     = flush_dx;
  assign bus.md_start     = md_start;
  assign bus.md_result_we = md_result_we;
  assign bus.fwd_a_sel    = fwd_sel(bus.dx_rs, bus.xm_we, bus.xm_rd, bus.mw_we, bus.mw_rd);
  assign bus.fwd_b_sel    = fwd_sel(bus.dx_rt, bus.xm_we, bus.xm_rd, bus.mw_we, bus.mw_rd);
  assign bus.md_timeout   = timeout_q;
  assign bus.stall_count  = count_q;
  assign bus.state        = state_q;

endmodule
